// File: rtl/uart_rx.sv
// 8N1 serial receiver: 16x oversampling from a fractional phase accumulator, 3-sample majority vote at mid-bit.
// state | meaning -- IDLE: wait for falling edge | START: verify start bit | DATA: shift 8 bits LSB first | STOP: check stop, deliver byte
module uart_rx #(
    parameter int unsigned CLK_HZ = 9600000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned OVS    = 16
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_n_i,
    input  logic       uart_rx_i,
    input  logic       uart_rd_i,
    output logic [7:0] uart_dat_o,
    output logic       uart_valid_o,
    output logic       uart_ferr_o,
    output logic       uart_ovr_o,
    output logic       uart_busy_o
);

    localparam logic [28:0] ACC_INC = 29'(BAUD * OVS);
    localparam logic [28:0] ACC_MOD = 29'(CLK_HZ);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [28:0] r_acc;
    logic [3:0]  r_cnt;
    logic [2:0]  r_bit;
    logic [1:0]  r_smp;
    logic [7:0]  r_shift;
    logic [7:0]  r_dat;
    logic        r_valid;
    logic        r_ferr;
    logic        r_ovr;

    logic [28:0] w_acc_sum;
    logic        w_tick;
    logic        w_rx;
    logic        w_fall;
    logic        w_vote;
    logic        w_rd_ok;

    assign w_acc_sum = r_acc + ACC_INC;
    assign w_tick    = (w_acc_sum >= ACC_MOD);
    assign w_rx      = r_sync2;
    assign w_fall    = r_prev & ~r_sync2;
    assign w_vote    = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx) | (r_smp[1] & w_rx);
    assign w_rd_ok   = uart_rd_i & r_valid;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_acc   <= '0;
        end else begin
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_acc   <= w_tick ? (w_acc_sum - ACC_MOD) : w_acc_sum;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_smp   <= '0;
            r_shift <= '0;
            r_dat   <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            if (w_rd_ok) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
            if (r_state != S_IDLE && w_tick) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd7) r_smp[0] <= w_rx;
                if (r_cnt == 4'd8) r_smp[1] <= w_rx;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end
                end
                S_START: begin
                    if (w_tick && r_cnt == 4'd9 && w_vote) r_state <= S_IDLE;
                    if (w_tick && r_cnt == 4'd15) r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_tick && r_cnt == 4'd9) r_shift <= {w_vote, r_shift[7:1]};
                    if (w_tick && r_cnt == 4'd15) begin
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick && r_cnt == 4'd9) begin
                        r_state <= S_IDLE;
                        if (w_vote) begin
                            // a read in the same cycle wins over the overrun set
                            r_dat   <= r_shift;
                            r_valid <= 1'b1;
                            r_ovr   <= r_valid & ~uart_rd_i;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign uart_dat_o   = r_dat;
    assign uart_valid_o = r_valid;
    assign uart_ferr_o  = r_ferr;
    assign uart_ovr_o   = r_ovr;
    assign uart_busy_o  = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive companion to the existing 8N1 UART transmitter. Deserialises the asynchronous serial line into bytes for the fabric.
- Runs on the 9.6 MHz system clock. Samples at 16x the baud rate using a fractional phase accumulator; majority-votes each bit at mid-bit.
- Presents each received byte with a valid/read handshake, and flags framing and overrun errors.

Parameters:
- CLK_HZ, 9600000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVS, 16, oversample factor; fixed at 16.

Ports:
- sys_clk_i  input  1  system clock, 9.6 MHz.
- sys_rst_n_i  input  1  system reset, asynchronous, active-low.
- uart_rx_i  input  1  serial line, idle high, asynchronous to sys_clk_i.
- uart_dat_o  output  8  last received byte.
- uart_valid_o  output  1  high while uart_dat_o holds an unread byte.
- uart_rd_i  input  1  read strobe; consumes the byte held in uart_dat_o.
- uart_ferr_o  output  1  one-cycle pulse when a frame is discarded because its stop bit sampled low.
- uart_ovr_o  output  1  sticky overrun flag; cleared by uart_rd_i.
- uart_busy_o  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset (sys_rst_n_i low, asynchronous): state IDLE; uart_dat_o=0x00; uart_valid_o=0; uart_ferr_o=0; uart_ovr_o=0; uart_busy_o=0; accumulator=0; sync flops=1.
- Input sync: two-flop synchroniser on uart_rx_i, followed by one further registered copy (prev) for edge detection. All logic below uses the synchronised value.
- Tick generator:
  - 29-bit accumulator, free-running.
  - Each cycle: acc += BAUD*OVS (1843200).
  - If the result >= CLK_HZ: subtract CLK_HZ and assert tick for one cycle.
  - Average is 5.208 clocks per tick, with no long-term drift.
- Tick counter: 4-bit, counts ticks within a bit. Reset to 0 on start-edge detection.
- State IDLE:
  - Enter START only on a falling edge (prev=1, current=0).
  - A line held low, e.g. a break, never retriggers.
- State START:
  - At tick counts 7, 8 and 9, take three samples and majority-vote them.
  - Vote = 1 at count 9: false start, return to IDLE with no output.
  - Vote = 0: move to DATA when the counter wraps 15->0.
- State DATA:
  - Each bit is the majority of the samples at counts 7/8/9.
  - Shift LSB first into the 8-bit shift register; the 3-bit bit index increments on wrap.
  - Move to STOP after bit 7 wraps.
- State STOP:
  - Majority vote at count 9.
  - Vote = 1 (good stop): load uart_dat_o from the shift register, set uart_valid_o, return to IDLE immediately at mid-stop. This allows back-to-back frames.
  - Vote = 0 (framing error): pulse uart_ferr_o for one cycle, leave uart_dat_o/uart_valid_o unchanged, return to IDLE.
- Latency: uart_valid_o rises about 9.5 bit times (about 792 clocks) plus 3 sync cycles after the start-bit falling edge.
- Handshake:
  - uart_rd_i while uart_valid_o=1: clear uart_valid_o and uart_ovr_o next cycle.
  - uart_rd_i while uart_valid_o=0: ignored.
- Overrun: a good stop while uart_valid_o=1 and no uart_rd_i in the same cycle overwrites uart_dat_o, keeps uart_valid_o=1, and sets uart_ovr_o.
- Simultaneous good stop and uart_rd_i: the new byte is loaded, uart_valid_o stays 1, uart_ovr_o is cleared (rd wins over set), and no overrun is flagged.
- Reset mid-frame: abort immediately to the reset values. After release, reception requires a fresh falling edge.
- Tolerance: must decode correctly with transmitter rate error up to ±3%.

Test Plan:
- Single byte: drive the 8N1 frame for 0xA5 at 115200 baud -> uart_valid_o=1 and uart_dat_o=0xA5 about 795 clocks after the start edge; uart_rd_i pulse -> uart_valid_o=0 next cycle; uart_ferr_o and uart_ovr_o stay 0.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap, reading each byte -> three valids with exactly those values; no errors.
- Loopback: connect the existing transmitter's uart_tx to uart_rx_i and send 0x00..0xFF -> all 256 bytes received in order.
- Glitch and framing:
  - 20-clock low pulse on an idle line -> no valid, returns to IDLE.
  - Frame 0x3C with the stop bit low -> one-cycle uart_ferr_o pulse, uart_valid_o stays 0.
  - Line then held low for 2 ms -> no further activity until the line returns high and falls again.
- Overrun: send 0x11 then 0x22 without reading -> uart_dat_o=0x22, uart_valid_o=1, uart_ovr_o=1; uart_rd_i clears both flags. Repeat with uart_rd_i coincident with the second stop-bit sample -> uart_dat_o=0x22, uart_valid_o=1, uart_ovr_o=0.
- Rate error and reset:
  - Send 0xC3 with a transmitter at +3% and at -3% baud -> both received as 0xC3.
  - Assert sys_rst_n_i during bit 4 of a frame -> all outputs at reset values asynchronously; the next clean frame 0x7E is received correctly.
